// File: rtl/onchip_ram_test_pkg.sv
// Shared types and constants for the on-chip RAM BIST master.
package onchip_ram_test_pkg;
  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 32;
  localparam int ERR_CNT_W  = 16;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;
endpackage

// File: rtl/onchip_ram_test_master_if.sv
// Avalon-MM bus between the BIST master and the RAM s2 slave port.
interface onchip_ram_test_master_if
  import onchip_ram_test_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              chipselect;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              clken;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, byteenable, chipselect, write, writedata, clken,
    input  readdata
  );
  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken,
    output readdata
  );
endinterface

// File: rtl/ram_test_checker.sv
// Read-latency delay line plus comparator, saturating error counter and
// first-error capture.
module ram_test_checker
  import onchip_ram_test_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 push,
  input  logic [ADDR_W-1:0]    push_addr,
  input  logic [DATA_W-1:0]    push_exp,
  input  logic [DATA_W-1:0]    readdata,
  output logic [ERR_CNT_W-1:0] error_count,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic [DATA_W-1:0]    first_err_data
);
  logic [READ_LATENCY-1:0] vld_pipe;
  logic [DATA_W-1:0]       exp_pipe  [READ_LATENCY];
  logic [ADDR_W-1:0]       addr_pipe [READ_LATENCY];
  logic                    mismatch;

  // The last stage lines up with the readdata returned for that read.
  assign mismatch = vld_pipe[READ_LATENCY-1] &&
                    (readdata != exp_pipe[READ_LATENCY-1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe       <= '0;
      for (int s = 0; s < READ_LATENCY; s++) begin
        exp_pipe[s]  <= '0;
        addr_pipe[s] <= '0;
      end
      error_count    <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else begin
      vld_pipe[0]  <= push;
      exp_pipe[0]  <= push_exp;
      addr_pipe[0] <= push_addr;
      for (int s = 1; s < READ_LATENCY; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        exp_pipe[s]  <= exp_pipe[s-1];
        addr_pipe[s] <= addr_pipe[s-1];
      end
      if (clear) begin
        error_count    <= '0;
        first_err_addr <= '0;
        first_err_data <= '0;
      end else if (mismatch) begin
        if (error_count != ERR_CNT_MAX)
          error_count <= error_count + ERR_CNT_W'(1);
        // Count only returns to zero on clear, so zero marks the first miss.
        if (error_count == '0) begin
          first_err_addr <= addr_pipe[READ_LATENCY-1];
          first_err_data <= readdata;
        end
      end
    end
  end
endmodule

// File: rtl/onchip_ram_test_master.sv
// BIST master: writes seed+i over a wrapping word range, reads it back and
// reports pass/fail through the checker.
module onchip_ram_test_master
  import onchip_ram_test_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      word_count,
  input  logic [DATA_W-1:0]    pattern_seed,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] error_count,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic [DATA_W-1:0]    first_err_data,
  onchip_ram_test_master_if.master bus
);
  localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W+1)'(1);
  localparam logic [2:0]      DRAIN_LAST = 3'(READ_LATENCY-1);

  state_t            state, state_d;
  logic [ADDR_W:0]   idx, idx_d, idx_nxt;
  logic [2:0]        drain_cnt, drain_d;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   cnt_q;
  logic [DATA_W-1:0] seed_q;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              cs_q, cs_d, wr_q, wr_d, clken_q;
  logic              busy_d, done_d, pass_d;
  logic              accept, last, push;

  assign bus.address    = address_q;
  assign bus.byteenable = be_q;
  assign bus.chipselect = cs_q;
  assign bus.write      = wr_q;
  assign bus.writedata  = wdata_q;
  assign bus.clken      = clken_q;

  assign accept  = (state == ST_IDLE) && start;
  assign idx_nxt = idx + IDX_ONE;
  assign last    = (idx == cnt_q - IDX_ONE);
  assign push    = (state == ST_READ);

  // Bus outputs are registered, so each state computes the command for the
  // following cycle; this removes any gap between the last write and first read.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    drain_d   = drain_cnt;
    address_d = address_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    cs_d      = cs_q;
    wr_d      = wr_q;
    busy_d    = busy;
    done_d    = 1'b0;
    pass_d    = pass;
    unique case (state)
      ST_IDLE: if (start) begin
        pass_d = 1'b0;
        if (word_count == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d   = ST_WRITE;
          idx_d     = '0;
          address_d = base_addr;
          wdata_d   = pattern_seed;
          be_d      = 4'hF;
          cs_d      = 1'b1;
          wr_d      = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_WRITE: if (last) begin
        state_d   = ST_READ;
        idx_d     = '0;
        address_d = base_q;
        wr_d      = 1'b0;
      end else begin
        idx_d     = idx_nxt;
        address_d = base_q + idx_nxt[ADDR_W-1:0];
        wdata_d   = seed_q + DATA_W'(idx_nxt);
      end
      ST_READ: if (last) begin
        state_d = ST_DRAIN;
        drain_d = '0;
        cs_d    = 1'b0;
        be_d    = 4'h0;
      end else begin
        idx_d     = idx_nxt;
        address_d = base_q + idx_nxt[ADDR_W-1:0];
      end
      ST_DRAIN: if (drain_cnt == DRAIN_LAST) begin
        state_d = ST_DONE;
        busy_d  = 1'b0;
      end else begin
        drain_d = drain_cnt + 3'd1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        pass_d  = (error_count == '0);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      drain_cnt <= '0;
      base_q    <= '0;
      cnt_q     <= '0;
      seed_q    <= '0;
      address_q <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      cs_q      <= 1'b0;
      wr_q      <= 1'b0;
      clken_q   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      drain_cnt <= drain_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      cs_q      <= cs_d;
      wr_q      <= wr_d;
      clken_q   <= 1'b1;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      if (accept) begin
        base_q <= base_addr;
        cnt_q  <= word_count;
        seed_q <= pattern_seed;
      end
    end
  end

  ram_test_checker #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .READ_LATENCY(READ_LATENCY)
  ) u_checker (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (accept),
    .push          (push),
    .push_addr     (address_q),
    .push_exp      (seed_q + DATA_W'(idx)),
    .readdata      (bus.readdata),
    .error_count   (error_count),
    .first_err_addr(first_err_addr),
    .first_err_data(first_err_data)
  );
endmodule

// File: tb/tb_onchip_ram_test_master.sv
// Bench for the RAM BIST master: RAM model with corruption/stuck-bit faults,
// per-cycle bus/result model, directed and randomized runs.
module tb_onchip_ram_test_master;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic [DW-1:0] pattern_seed = '0;
  logic          busy, done, pass;
  logic [15:0]   error_count;
  logic [AW-1:0] first_err_addr;
  logic [DW-1:0] first_err_data;

  onchip_ram_test_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  onchip_ram_test_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .base_addr     (base_addr),
    .word_count    (word_count),
    .pattern_seed  (pattern_seed),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .error_count   (error_count),
    .first_err_addr(first_err_addr),
    .first_err_data(first_err_data),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // RAM model with optional bit0-stuck-at-0 and a one-shot word overwrite
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] rd_pipe [RL];
  bit            stuck = 1'b0;
  int            corrupt_edge = -1;
  logic [AW-1:0] corrupt_addr = '0;
  logic [DW-1:0] corrupt_data = '0;

  assign bus.readdata = rd_pipe[RL-1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int s = 1; s < RL; s++) rd_pipe[s] <= rd_pipe[s-1];
    rd_pipe[0] <= '0;
    if (bus.clken && bus.chipselect) begin
      if (bus.write) begin
        for (int b = 0; b < 4; b++)
          if (bus.byteenable[b])
            mem[bus.address][8*b +: 8] <= bus.writedata[8*b +: 8] & ((stuck && b == 0) ? 8'hFE : 8'hFF);
      end else begin
        rd_pipe[0] <= mem[bus.address];
      end
    end
    if (cyc + 1 == corrupt_edge) mem[corrupt_addr] <= corrupt_data;
  end

  // Model of the run in flight (written only by the stimulus process)
  bit            m_act = 1'b0;
  int            m_k = 0;
  int            m_n = 0;
  logic [AW-1:0] m_base = '0;
  logic [DW-1:0] m_seed = '0;
  int            m_err = 0;
  logic [AW-1:0] m_faddr = '0;
  logic [DW-1:0] m_fdata = '0;

  // Cycle c = edges since the start-sampling edge k
  always @(negedge clk) begin
    int c, dc;
    bit cs_e, wr_e, busy_e;
    if (reset_n) begin
      c  = cyc - m_k;
      dc = (m_n == 0) ? 1 : 2*m_n + RL + 1;
      if (m_act && c >= 0 && c <= dc) begin
        cs_e   = (c < 2*m_n);
        wr_e   = (c < m_n);
        busy_e = (m_n > 0) && (c < 2*m_n + RL);
        chk("chipselect", bus.chipselect, cs_e);
        chk("write", bus.write, wr_e);
        chk("busy", busy, busy_e);
        chk("done", done, c == dc);
        if (cs_e) begin
          chk("address", bus.address, AW'(m_base + (wr_e ? c : c - m_n)));
          chk("byteenable", bus.byteenable, 4'hF);
          if (wr_e) chk("writedata", bus.writedata, DW'(m_seed + c));
        end else begin
          chk("byteenable_off", bus.byteenable, 4'h0);
        end
        if (c == dc) begin
          chk("pass", pass, m_err == 0);
          chk("error_count", error_count, m_err);
          if (m_err > 0) begin
            chk("first_err_addr", first_err_addr, m_faddr);
            chk("first_err_data", first_err_data, m_fdata);
          end
        end
      end else begin
        chk("done_idle", done, 1'b0);
        chk("cs_idle", bus.chipselect, 1'b0);
        chk("busy_idle", busy, 1'b0);
        chk("clken", bus.clken, 1'b1);
        if (m_act && c > dc) begin
          chk("pass_hold", pass, m_err == 0);
          chk("err_hold", error_count, m_err);
        end
      end
    end
  end

  task automatic start_run(input logic [AW-1:0] b, input int n, input logic [DW-1:0] s,
                           input bit corrupt, input int cj, input logic [DW-1:0] cd);
    int err;
    bit found;
    logic [DW-1:0] p, r;
    err = 0; found = 0;
    for (int i = 0; i < n; i++) begin
      p = DW'(s + i);
      r = (corrupt && i == cj) ? cd : (stuck ? (p & ~DW'(1)) : p);
      if (r != p) begin
        err++;
        if (!found) begin
          found   = 1;
          m_faddr = AW'(b + i);
          m_fdata = r;
        end
      end
    end
    @(negedge clk);
    m_err  = (err > 65535) ? 65535 : err;
    m_base = b; m_n = n; m_seed = s;
    m_k    = cyc + 1;
    m_act  = 1'b1;
    corrupt_edge = corrupt ? m_k + n + 1 : -1;
    corrupt_addr = AW'(b + cj);
    corrupt_data = cd;
    base_addr = b; word_count = (AW+1)'(n); pattern_seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base_addr = AW'($urandom); pattern_seed = $urandom; word_count = (AW+1)'($urandom);
  endtask

  task automatic wait_done(input int budget, output int dc);
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        dc = cyc - m_k;
        break;
      end
      @(negedge clk);
    end
    if (dc < 0) chk("done_timeout", done, 1'b1);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int dc, n, cj;
    bit cor;
    logic [AW-1:0] b;
    logic [DW-1:0] s;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_err", error_count, 16'h0);
    chk("rst_faddr", first_err_addr, '0);
    chk("rst_fdata", first_err_data, '0);
    chk("rst_address", bus.address, '0);
    chk("rst_writedata", bus.writedata, '0);
    chk("rst_be", bus.byteenable, 4'h0);
    chk("rst_cs", bus.chipselect, 1'b0);
    chk("rst_write", bus.write, 1'b0);
    chk("rst_clken", bus.clken, 1'b1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean run
    start_run(15'h0010, 4, 32'hA5A50000, 0, 0, '0);
    wait_done(40, dc);
    chk("t1_latency", dc, 10);
    chk("t1_mem10", mem[15'h0010], 32'hA5A50000);
    chk("t1_mem13", mem[15'h0013], 32'hA5A50003);
    chk("t1_pass", pass, 1'b1);
    chk("t1_err", error_count, 16'd0);

    // Address wrap
    start_run(15'h7FFE, 4, 32'h12345678, 0, 0, '0);
    wait_done(40, dc);
    chk("t2_latency", dc, 10);
    chk("t2_mem7fff", mem[15'h7FFF], 32'h12345679);
    chk("t2_mem0000", mem[15'h0000], 32'h1234567A);
    chk("t2_mem0001", mem[15'h0001], 32'h1234567B);
    chk("t2_pass", pass, 1'b1);

    // Word 0x12 overwritten between write and read phases
    start_run(15'h0010, 4, 32'hA5A50000, 1, 2, 32'hDEADBEEF);
    wait_done(40, dc);
    chk("t3_err", error_count, 16'd1);
    chk("t3_pass", pass, 1'b0);
    chk("t3_faddr", first_err_addr, 15'h0012);
    chk("t3_fdata", first_err_data, 32'hDEADBEEF);

    // Zero-length run
    start_run(15'h0123, 0, 32'h0, 0, 0, '0);
    wait_done(10, dc);
    chk("t4_latency", dc, 1);
    chk("t4_pass", pass, 1'b1);

    // Start pulses during WRITE are ignored
    start_run(15'h0200, 8, 32'h00C0FFEE, 0, 0, '0);
    start = 1'b1; base_addr = 15'h0777; word_count = '0; pattern_seed = 32'h5;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done(60, dc);
    chk("t5_latency", dc, 18);
    chk("t5_pass", pass, 1'b1);

    // Reset mid-READ aborts, then a fresh run completes
    start_run(15'h0300, 16, 32'h0BADF00D, 0, 0, '0);
    while (cyc - m_k < 19) @(negedge clk);
    reset_n = 1'b0;
    m_act = 1'b0;
    #1;
    chk("t6_cs_async", bus.chipselect, 1'b0);
    chk("t6_write_async", bus.write, 1'b0);
    chk("t6_busy_async", busy, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    start_run(15'h0300, 16, 32'h0BADF00D, 0, 0, '0);
    wait_done(60, dc);
    chk("t6_pass", pass, 1'b1);

    // Randomized runs, some with an injected corruption
    for (int t = 0; t < 10; t++) begin
      b   = AW'($urandom);
      n   = $urandom_range(0, 40);
      s   = $urandom;
      cor = (n >= 2) && ($urandom_range(0, 1) == 1);
      cj  = (n >= 2) ? $urandom_range(1, n - 1) : 0;
      start_run(b, n, s, cor, cj, $urandom);
      wait_done(2*n + 20, dc);
    end

    // Full-size run with bit0 stuck at 0: every odd pattern word fails
    stuck = 1'b1;
    start_run(15'h0000, 32768, 32'h00001000, 0, 0, '0);
    wait_done(70000, dc);
    chk("t7_latency", dc, 65538);
    chk("t7_err", error_count, 16'd16384);
    chk("t7_pass", pass, 1'b0);
    chk("t7_faddr", first_err_addr, 15'h0001);
    chk("t7_fdata", first_err_data, 32'h00001000);
    stuck = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
